pmmu_arbiter: RTL and testbench
===============================

# pmmu_arbiter

Two-port arbiter that shares the single Pmmu memory port between the CPU datapath (ControlMatrix strobes plus address/funct3 muxes) and the console debug port. It sits between those requesters and the Pmmu. It drives the ControlMatrix `mem_busy_i` input so the sequencer stalls while the debugger owns memory. It also bounds every access with a watchdog.

## Interface
- `DATA_WIDTH`, 32, data and address width
- `TIMEOUT_CYCLES`, 15, maximum cycles to wait for `mem_rdy_i` (1..15)
- `clk_i`  in  1  single clock, rising edge
- `reset_i`  in  1  asynchronous, active-low reset
- `cpu_rd_i` / `cpu_wr_i`  in  1  CPU read/write request levels (ControlMatrix `mem_rd_o`/`mem_wr_o`)
- `cpu_addr_i`  in  DATA_WIDTH  CPU byte address
- `cpu_wd_i`  in  DATA_WIDTH  CPU write data
- `cpu_funct3_i`  in  3  CPU access size/sign
- `cpu_busy_o`  out  1  stall to ControlMatrix
- `cpu_done_o`  out  1  one-cycle completion pulse
- `cpu_rd_data_o`  out  DATA_WIDTH  captured read data
- `dbg_req_i`  in  1  debug request level
- `dbg_we_i`  in  1  debug write (1) or read (0)
- `dbg_addr_i`, `dbg_wd_i`  in  DATA_WIDTH  debug address and write data
- `dbg_ack_o`  out  1  one-cycle completion pulse
- `dbg_rd_data_o`  out  DATA_WIDTH  captured read data
- `mem_addr_o`, `mem_wd_o`  out  DATA_WIDTH  to Pmmu
- `mem_rd_o`, `mem_wr_o`  out  1  to Pmmu
- `mem_funct3_o`  out  3  to Pmmu
- `mem_rd_data_i`  in  DATA_WIDTH  Pmmu read data
- `mem_rdy_i`  in  1  Pmmu ready
- `err_o`  out  1  one-cycle watchdog-timeout pulse; `err_src_o`  out  1  0=CPU, 1=debug

## Operation
- States: IDLE, CPU_ACC, CPU_DONE, DBG_ACC, DBG_DONE.
- IDLE: with a CPU request (`cpu_rd_i|cpu_wr_i`) and/or `dbg_req_i`, grant one requester.
  - When both request, round-robin: grant the requester not served last. The `last` bit resets to debug, so the CPU wins the first tie.
- Grant: latch address, write data, funct3 and direction into output registers. Debug accesses always use funct3 = 3'b010 (word).
- CPU_ACC/DBG_ACC: hold the strobes and clear the watchdog.
  - `mem_rdy_i` high: capture `mem_rd_data_i` (reads only), drop the strobes, go to *_DONE.
  - Watchdog reaches `TIMEOUT_CYCLES` first: drop the strobes, pulse `err_o`, set `err_src_o`, go to *_DONE. Read data captured as 0.
- CPU_DONE: `cpu_done_o`=1, go to IDLE. DBG_DONE: `dbg_ack_o`=1, go to IDLE.
- `cpu_busy_o` = CPU request asserted AND state ≠ CPU_DONE (combinational).
- Requester rules:
  - A request still asserted on the cycle after done/ack counts as a new access.
  - `dbg_*` inputs stay stable while `dbg_req_i` is high.
  - A CPU request that drops mid-access does not abort that access.
- `mem_rd_o` and `mem_wr_o` are never high together. If `cpu_rd_i` and `cpu_wr_i` are both high, write wins.

## Timing
- Reset (async assert, sync release): state IDLE, `last` = debug, watchdog 0. Every output is 0, including both data captures.
- Reset mid-access drops the strobes immediately. No done/ack/err pulse is issued.
- Latency: a request sampled in IDLE at edge N gives strobes at N+1.
  - With `mem_rdy_i` high in that same cycle, *_DONE at N+2 and the pulse lasts one cycle.
  - Minimum 3 cycles request-to-IDLE.
- Read data is valid from the done/ack cycle and holds until the next same-port read completes.
- The watchdog counts cycles spent in *_ACC. A timeout fires on the `TIMEOUT_CYCLES`-th cycle without `mem_rdy_i`. If `mem_rdy_i` is high on that same cycle, it completes normally.

## Structure
- Shared definitions package holds:
  - the state enum
  - the requester ID constants (`REQ_CPU`=0, `REQ_DBG`=1)
  - the `WORD_FUNCT3`=3'b010 constant
  - the watchdog counter width
- Data captures reuse the existing `Register` module. No other sub-module.

## Test plan
- CPU read of 0x40 alone, `mem_rdy_i` tied 1, `mem_rd_data_i`=0xDEADBEEF.
  - Required: strobes at N+1 with funct3 from CPU; `cpu_done_o` at N+2; `cpu_rd_data_o`=0xDEADBEEF; `cpu_busy_o` low only in CPU_DONE.
- Debug write of 0x12345678 to 0x100.
  - Required: `mem_wr_o`=1, `mem_funct3_o`=3'b010, `dbg_ack_o` pulses once; `cpu_busy_o` high throughout for a concurrently held CPU request.
- CPU and debug request in the same cycle, repeated 4 times.
  - Required: grants alternate CPU, debug, CPU, debug.
- `mem_rdy_i` held 0 with `TIMEOUT_CYCLES`=15.
  - Required: `err_o` pulses after 15 cycles in CPU_ACC with `err_src_o`=0; `cpu_done_o` follows; `cpu_rd_data_o`=0.
- `reset_i` driven low during DBG_ACC.
  - Required: all outputs 0 asynchronously, no ack. After release, the first tie goes to the CPU.

Source files
------------

// File: rtl/pmmu_arbiter_pkg.sv
// Shared definitions for the Pmmu port arbiter: FSM states, requester IDs,
// the fixed debug access size and the watchdog counter width.
package pmmu_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_ACC,
    ST_CPU_DONE,
    ST_DBG_ACC,
    ST_DBG_DONE
  } state_e;

  localparam logic       REQ_CPU     = 1'b0;
  localparam logic       REQ_DBG     = 1'b1;
  localparam logic [2:0] WORD_FUNCT3 = 3'b010;
  localparam int         WDOG_W      = 4;

  function automatic logic is_acc(input state_e s);
    return (s == ST_CPU_ACC) || (s == ST_DBG_ACC);
  endfunction

endpackage

// File: rtl/pmmu_arbiter_if.sv
// Bundle of CPU, debug and Pmmu signals around the arbiter. The slave modport
// is the arbiter's view; the master modport is the surrounding requesters/Pmmu.
interface pmmu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_rd_i;
  logic                  cpu_wr_i;
  logic [DATA_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wd_i;
  logic [2:0]            cpu_funct3_i;
  logic                  cpu_busy_o;
  logic                  cpu_done_o;
  logic [DATA_WIDTH-1:0] cpu_rd_data_o;

  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [DATA_WIDTH-1:0] dbg_addr_i;
  logic [DATA_WIDTH-1:0] dbg_wd_i;
  logic                  dbg_ack_o;
  logic [DATA_WIDTH-1:0] dbg_rd_data_o;

  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [2:0]            mem_funct3_o;
  logic [DATA_WIDTH-1:0] mem_rd_data_i;
  logic                  mem_rdy_i;

  logic                  err_o;
  logic                  err_src_o;

  modport slave (
    input  cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_wd_i, cpu_funct3_i,
    output cpu_busy_o, cpu_done_o, cpu_rd_data_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wd_i,
    output dbg_ack_o, dbg_rd_data_o,
    output mem_addr_o, mem_wd_o, mem_rd_o, mem_wr_o, mem_funct3_o,
    input  mem_rd_data_i, mem_rdy_i,
    output err_o, err_src_o
  );

  modport master (
    output cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_wd_i, cpu_funct3_i,
    input  cpu_busy_o, cpu_done_o, cpu_rd_data_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wd_i,
    input  dbg_ack_o, dbg_rd_data_o,
    input  mem_addr_o, mem_wd_o, mem_rd_o, mem_wr_o, mem_funct3_o,
    output mem_rd_data_i, mem_rdy_i,
    input  err_o, err_src_o
  );

endinterface

// File: rtl/Register.sv
// Enabled data register with asynchronous active-low clear; used for the
// read-data captures of both arbiter ports.
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pmmu_arbiter.sv
// Shares the single Pmmu port between the CPU datapath and the debug port,
// round-robin on ties, with a per-access watchdog that forces completion.
module pmmu_arbiter
  import pmmu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic         clk_i,
  input  logic         reset_i,
  pmmu_arbiter_if.slave bus
);

  localparam logic [WDOG_W-1:0] LP_WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  state_e                  r_state;
  logic                    r_last;
  logic [WDOG_W-1:0]       r_wdog;
  logic [DATA_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wd;
  logic                    r_mem_rd;
  logic                    r_mem_wr;
  logic [2:0]              r_mem_funct3;
  logic                    r_cpu_done;
  logic                    r_dbg_ack;
  logic                    r_err;
  logic                    r_err_src;

  logic                    w_cpu_req;
  logic                    w_grant_cpu;
  logic                    w_acc_end;
  logic                    w_cpu_cap;
  logic                    w_dbg_cap;
  logic [DATA_WIDTH-1:0]   w_cap_data;
  logic [DATA_WIDTH-1:0]   w_cpu_rd_data;
  logic [DATA_WIDTH-1:0]   w_dbg_rd_data;

  assign w_cpu_req   = bus.cpu_rd_i | bus.cpu_wr_i;
  // On a tie the requester that was not served last wins.
  assign w_grant_cpu = w_cpu_req && (!bus.dbg_req_i || (r_last == REQ_DBG));
  assign w_acc_end   = bus.mem_rdy_i || (r_wdog == LP_WDOG_LAST);

  // A timed-out read still completes, returning zero instead of Pmmu data.
  assign w_cap_data  = bus.mem_rdy_i ? bus.mem_rd_data_i : '0;
  assign w_cpu_cap   = (r_state == ST_CPU_ACC) && r_mem_rd && w_acc_end;
  assign w_dbg_cap   = (r_state == ST_DBG_ACC) && r_mem_rd && w_acc_end;

  Register #(.WIDTH(DATA_WIDTH)) u_cpu_rd_data (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_cpu_cap),
    .d_i     (w_cap_data),
    .q_o     (w_cpu_rd_data)
  );

  Register #(.WIDTH(DATA_WIDTH)) u_dbg_rd_data (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_dbg_cap),
    .d_i     (w_cap_data),
    .q_o     (w_dbg_rd_data)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= ST_IDLE;
      r_last       <= REQ_DBG;
      r_wdog       <= '0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_funct3 <= '0;
      r_cpu_done   <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_err        <= 1'b0;
      r_err_src    <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_dbg_ack  <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_cpu) begin
            r_mem_addr   <= bus.cpu_addr_i;
            r_mem_wd     <= bus.cpu_wd_i;
            r_mem_funct3 <= bus.cpu_funct3_i;
            // Write wins when the CPU raises both strobes.
            r_mem_wr     <= bus.cpu_wr_i;
            r_mem_rd     <= ~bus.cpu_wr_i;
            r_last       <= REQ_CPU;
            r_wdog       <= '0;
            r_state      <= ST_CPU_ACC;
          end else if (bus.dbg_req_i) begin
            r_mem_addr   <= bus.dbg_addr_i;
            r_mem_wd     <= bus.dbg_wd_i;
            r_mem_funct3 <= WORD_FUNCT3;
            r_mem_wr     <= bus.dbg_we_i;
            r_mem_rd     <= ~bus.dbg_we_i;
            r_last       <= REQ_DBG;
            r_wdog       <= '0;
            r_state      <= ST_DBG_ACC;
          end
        end
        ST_CPU_ACC, ST_DBG_ACC: begin
          if (w_acc_end) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_err    <= ~bus.mem_rdy_i;
            if (!bus.mem_rdy_i) begin
              r_err_src <= (r_state == ST_DBG_ACC) ? REQ_DBG : REQ_CPU;
            end
            if (r_state == ST_CPU_ACC) begin
              r_cpu_done <= 1'b1;
              r_state    <= ST_CPU_DONE;
            end else begin
              r_dbg_ack <= 1'b1;
              r_state   <= ST_DBG_DONE;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_CPU_DONE, ST_DBG_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The sequencer is released only in the completion cycle of its own access.
  assign bus.cpu_busy_o    = reset_i && w_cpu_req && (r_state != ST_CPU_DONE) &&
                             (is_acc(r_state) || (r_state != ST_CPU_DONE));
  assign bus.cpu_done_o    = r_cpu_done;
  assign bus.cpu_rd_data_o = w_cpu_rd_data;
  assign bus.dbg_ack_o     = r_dbg_ack;
  assign bus.dbg_rd_data_o = w_dbg_rd_data;
  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.mem_wd_o      = r_mem_wd;
  assign bus.mem_rd_o      = r_mem_rd;
  assign bus.mem_wr_o      = r_mem_wr;
  assign bus.mem_funct3_o  = r_mem_funct3;
  assign bus.err_o         = r_err;
  assign bus.err_src_o     = r_err_src;

endmodule

// File: tb/tb_pmmu_arbiter.sv
// Bench for pmmu_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pmmu_arbiter;

  localparam int DW = 32;
  localparam int T  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmmu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  pmmu_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference model: the current transaction and where it is in its life
  // (0 = no access, 1 = on the bus, 2 = completion cycle).
  int          m_phase     = 0;
  int          m_age       = 0;
  bit          m_last      = 1'b1;
  bit          m_port      = 1'b0;
  bit          m_wr        = 1'b0;
  bit          m_timeout   = 1'b0;
  bit          m_err_src   = 1'b0;
  logic [31:0] m_addr      = '0;
  logic [31:0] m_wd        = '0;
  logic [2:0]  m_f3        = '0;
  logic [31:0] m_cpu_rdata = '0;
  logic [31:0] m_dbg_rdata = '0;
  bit          grants[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_last = 1'b1; m_port = 1'b0; m_wr = 1'b0;
      m_timeout = 1'b0; m_err_src = 1'b0; m_addr = '0; m_wd = '0; m_f3 = '0;
      m_cpu_rdata = '0; m_dbg_rdata = '0;
    end else if (m_phase == 0) begin
      if (bus.cpu_rd_i || bus.cpu_wr_i || bus.dbg_req_i) begin
        if ((bus.cpu_rd_i || bus.cpu_wr_i) && bus.dbg_req_i) m_port = ~m_last;
        else m_port = !(bus.cpu_rd_i || bus.cpu_wr_i);
        if (!m_port) begin
          m_addr = bus.cpu_addr_i; m_wd = bus.cpu_wd_i; m_f3 = bus.cpu_funct3_i; m_wr = bus.cpu_wr_i;
        end else begin
          m_addr = bus.dbg_addr_i; m_wd = bus.dbg_wd_i; m_f3 = 3'b010; m_wr = bus.dbg_we_i;
        end
        m_last = m_port; m_age = 0; m_timeout = 1'b0; m_phase = 1;
        grants.push_back(m_port);
      end
    end else if (m_phase == 1) begin
      m_age++;
      if (bus.mem_rdy_i || m_age == T) begin
        m_timeout = !bus.mem_rdy_i;
        if (m_timeout) m_err_src = m_port;
        if (!m_wr) begin
          if (!m_port) m_cpu_rdata = m_timeout ? 32'h0 : bus.mem_rd_data_i;
          else         m_dbg_rdata = m_timeout ? 32'h0 : bus.mem_rd_data_i;
        end
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    chk1("cpu_busy", bus.cpu_busy_o,
         rst_n && (bus.cpu_rd_i || bus.cpu_wr_i) && !(m_phase == 2 && !m_port));
    chk1("cpu_done", bus.cpu_done_o, m_phase == 2 && !m_port);
    chk1("dbg_ack", bus.dbg_ack_o, m_phase == 2 && m_port);
    chk1("err", bus.err_o, m_phase == 2 && m_timeout);
    chk1("err_src", bus.err_src_o, m_err_src);
    chk1("mem_rd", bus.mem_rd_o, m_phase == 1 && !m_wr);
    chk1("mem_wr", bus.mem_wr_o, m_phase == 1 && m_wr);
    chk("mem_addr", bus.mem_addr_o, m_addr);
    chk("mem_wd", bus.mem_wd_o, m_wd);
    chk("mem_funct3", {29'b0, bus.mem_funct3_o}, {29'b0, m_f3});
    chk("cpu_rd_data", bus.cpu_rd_data_o, m_cpu_rdata);
    chk("dbg_rd_data", bus.dbg_rd_data_o, m_dbg_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.cpu_rd_i = 1'b0; bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wd_i = '0;
    bus.cpu_funct3_i = '0; bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0;
    bus.dbg_wd_i = '0; bus.mem_rd_data_i = '0; bus.mem_rdy_i = 1'b0;
  endtask

  initial begin
    int n;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk1("rst_mem_rd", bus.mem_rd_o, 1'b0);
    chk1("rst_cpu_done", bus.cpu_done_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // CPU read of 0x40, Pmmu ready immediately.
    bus.cpu_rd_i = 1'b1; bus.cpu_addr_i = 32'h40; bus.cpu_funct3_i = 3'b100;
    bus.mem_rdy_i = 1'b1; bus.mem_rd_data_i = 32'hDEADBEEF;
    tick();
    chk1("t1_mem_rd", bus.mem_rd_o, 1'b1);
    chk("t1_addr", bus.mem_addr_o, 32'h40);
    chk("t1_funct3", {29'b0, bus.mem_funct3_o}, 32'h4);
    chk1("t1_busy_acc", bus.cpu_busy_o, 1'b1);
    tick();
    chk1("t1_done", bus.cpu_done_o, 1'b1);
    chk("t1_rdata", bus.cpu_rd_data_o, 32'hDEADBEEF);
    chk1("t1_busy_done", bus.cpu_busy_o, 1'b0);
    bus.cpu_rd_i = 1'b0;
    tick();
    chk1("t1_done_clr", bus.cpu_done_o, 1'b0);

    // Debug write against a held CPU read; CPU was served last so debug wins.
    bus.cpu_rd_i = 1'b1; bus.cpu_addr_i = 32'h44; bus.cpu_funct3_i = 3'b010;
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 32'h100; bus.dbg_wd_i = 32'h12345678;
    bus.mem_rd_data_i = 32'h55AA55AA;
    tick();
    chk1("t2_mem_wr", bus.mem_wr_o, 1'b1);
    chk1("t2_mem_rd", bus.mem_rd_o, 1'b0);
    chk("t2_funct3", {29'b0, bus.mem_funct3_o}, 32'h2);
    chk("t2_addr", bus.mem_addr_o, 32'h100);
    chk("t2_wd", bus.mem_wd_o, 32'h12345678);
    chk1("t2_busy_acc", bus.cpu_busy_o, 1'b1);
    tick();
    chk1("t2_ack", bus.dbg_ack_o, 1'b1);
    chk1("t2_busy_ack", bus.cpu_busy_o, 1'b1);
    bus.dbg_req_i = 1'b0;
    tick();
    chk1("t2_ack_once", bus.dbg_ack_o, 1'b0);
    chk1("t2_busy_idle", bus.cpu_busy_o, 1'b1);
    tick();
    chk("t2_cpu_addr", bus.mem_addr_o, 32'h44);
    tick();
    chk("t2_cpu_rdata", bus.cpu_rd_data_o, 32'h55AA55AA);
    bus.cpu_rd_i = 1'b0;
    tick();

    // Watchdog: Pmmu never ready.
    bus.cpu_rd_i = 1'b1; bus.cpu_addr_i = 32'h80; bus.cpu_funct3_i = 3'b001; bus.mem_rdy_i = 1'b0;
    tick();
    n = 1;
    while (!bus.err_o && n < 20) begin
      tick();
      n++;
    end
    chk("t4_err_cycle", n, 16);
    chk1("t4_err_src", bus.err_src_o, 1'b0);
    chk1("t4_done", bus.cpu_done_o, 1'b1);
    chk("t4_rdata", bus.cpu_rd_data_o, 32'h0);
    bus.cpu_rd_i = 1'b0;
    tick();

    // Reset while a debug read is stalled on the bus.
    bus.cpu_rd_i = 1'b1; bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 32'h200;
    tick();
    tick();
    chk1("t5_mem_rd_pre", bus.mem_rd_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("t5_mem_rd", bus.mem_rd_o, 1'b0);
    chk("t5_addr", bus.mem_addr_o, 32'h0);
    chk1("t5_busy", bus.cpu_busy_o, 1'b0);
    chk("t5_cpu_rdata", bus.cpu_rd_data_o, 32'h0);
    bus.cpu_rd_i = 1'b0; bus.dbg_req_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk1("t5_no_ack", bus.dbg_ack_o, 1'b0);

    // Four simultaneous requests: grants must alternate starting with the CPU.
    for (int r = 0; r < 4; r++) begin
      bus.cpu_rd_i = 1'b1; bus.cpu_addr_i = 32'hA0; bus.mem_rdy_i = 1'b1;
      bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 32'hB0;
      tick();
      chk("t3_grant_addr", bus.mem_addr_o, (r % 2 == 0) ? 32'hA0 : 32'hB0);
      bus.cpu_rd_i = 1'b0; bus.dbg_req_i = 1'b0;
      tick();
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      chk1("t3_model_grant", grants[grants.size() - 4 + r], (r % 2) == 1);
    end

    // Randomized traffic with periodic Pmmu stalls long enough to time out.
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        bus.cpu_rd_i = 1'($urandom); bus.cpu_wr_i = 1'($urandom);
        bus.cpu_addr_i = $urandom; bus.cpu_wd_i = $urandom; bus.cpu_funct3_i = 3'($urandom);
      end
      if (!bus.dbg_req_i) begin
        if ($urandom_range(2) == 0) begin
          bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'($urandom);
          bus.dbg_addr_i = $urandom; bus.dbg_wd_i = $urandom;
        end
      end else if ($urandom_range(3) == 0) begin
        bus.dbg_req_i = 1'b0;
      end
      bus.mem_rdy_i = ((c % 80) < 22) ? 1'b0 : ($urandom_range(2) == 0);
      bus.mem_rd_data_i = $urandom;
      tick();
    end

    idle_inputs();
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
